alu_issue_stage: RTL
====================

# alu_issue_stage

ID/EX pipeline stage sitting directly upstream of the ALU in the RISC-V core. Accepts one decoded ALU instruction per cycle from decode and holds it in a single-entry buffer with valid/ready handshake. Drives the ALU's `A`, `B` and `ALU_Sel` inputs, resolving RAW hazards by forwarding from EX/MEM and MEM/WB or by stalling.

## Interface
- `XLEN`, 32, datapath width
- `clk` in 1, rising-edge clock
- `rst` in 1, asynchronous, active-high reset
- `in_valid` in 1 / `in_ready` out 1, decode handshake
- `in_rs1`, `in_rs2`, `in_rd` in 5, register addresses
- `in_rs1_data`, `in_rs2_data`, `in_imm` in XLEN, register-file read data and immediate
- `in_use_imm` in 1, B = immediate instead of rs2
- `in_alu_sel` in 4, ALU op code
- `in_reg_write` in 1, instruction writes rd
- `flush` in 1, kill held entry (branch redirect)
- `exmem_rd` in 5, `exmem_reg_write` in 1, `exmem_is_load` in 1, `exmem_result` in XLEN
- `memwb_rd` in 5, `memwb_reg_write` in 1, `memwb_result` in XLEN
- `out_valid` out 1 / `out_ready` in 1, ALU-side handshake
- `A`, `B` out XLEN, ALU operands
- `ALU_Sel` out 4, `out_rd` out 5, `out_reg_write` out 1
- `stall_count` out 16, saturating count of stall cycles

## Operation
- States: EMPTY, FULL. Transfers on `in_valid && in_ready` and `out_valid && out_ready`.
- `in_ready = EMPTY || (out_valid && out_ready)`. Accept while FULL and draining is a replace, with no bubble.
- Capture bypass: at accept, if `memwb_reg_write && memwb_rd == in_rsN && in_rsN != 0`, store `memwb_result` instead of `in_rsN_data`. This is register-file write-through.
- Hold refresh: while FULL and not draining, if MEM/WB matches a held rs (nonzero), the stored operand is overwritten with `memwb_result`, so producer values are not lost as they retire.
- Forwarding on held operand N (rsN != 0, B only when `use_imm` = 0):
  - EX/MEM match with reg_write, not a load: `exmem_result`.
  - Otherwise, MEM/WB match: `memwb_result`.
  - Otherwise: the stored value.
  - EX/MEM has priority.
- Load-use: an EX/MEM match with `exmem_is_load` forces `out_valid` = 0 for that cycle (hazard stall).
- `out_valid = FULL && !hazard`. `B = use_imm ? imm : fwd_rs2`.
- `flush`: FULL→EMPTY at the next edge. It has priority over a simultaneous accept, which is blocked because `in_ready` = 0 during flush.
- `stall_count` increments each cycle FULL && (hazard || !out_ready), and saturates at 0xFFFF.
- x0 is never forwarded and never stalls.

## Timing
- Reset (async): EMPTY, `out_valid` = 0, `A`/`B` = 0, `ALU_Sel` = 0, `out_rd` = 0, `out_reg_write` = 0, `stall_count` = 0. `in_ready` = 1 after reset.
- Latency: accept at edge N gives `out_valid` in cycle N+1 if no hazard.
- Load-use adds exactly 1 cycle: the load moves to MEM/WB and is then forwarded.
- `A`/`B`/`ALU_Sel` are stable while `out_valid && !out_ready`.
- Reset mid-hold drops the entry, with no output pulse.

## Configuration
- `ALU_FORWARDING_EN` defined: forwarding as above.
- `ALU_FORWARDING_EN` undefined: no EX/MEM/MEM/WB forwarding muxes. Any EX/MEM or MEM/WB match with reg_write is a hazard, and `out_valid` is held low until the match clears. Capture bypass and hold refresh remain.

## Structure
- `alu_pkg`: `ALU_Sel` encodings AND=0000, OR=0001, ADD=0010, SLL=0011, SUB=0100, SRL=0101, MUL=0110, XOR=0111; also the state enum and XLEN.
- Sub-module `operand_forward_mux`, instantiated twice (rs1, rs2). It returns the forwarded value and the hazard bit.

## Test plan
- Reset then accept ADD rs1=x1(5), rs2=x2(3) → next cycle `out_valid`=1, A=5, B=3, `ALU_Sel`=0010.
- Held SUB x3,x4, `exmem_rd`=x3, `exmem_result`=9, same cycle MEM/WB x3=7 → A=9 (EX/MEM priority).
- Held entry rs1=x5, EX/MEM load to x5 → `out_valid`=0 one cycle. Next cycle MEM/WB x5=0x10 → A=0x10, `out_valid`=1, `stall_count`=1.
- `out_ready`=0 for 3 cycles with new `in_valid` → `in_ready`=0, outputs constant, `stall_count`=3. Raise `out_ready` → back-to-back accept with no bubble.
- `flush` while FULL with `in_valid`=1 → next cycle `out_valid`=0, nothing accepted. rs1=x0 with `exmem_rd`=0 → A=0, no stall.
- Without `ALU_FORWARDING_EN`: EX/MEM non-load match on rs2 → `out_valid` low until the match clears. B then equals the hold-refreshed MEM/WB value.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: ALU op encodings, stage state and datapath width.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SLL = 4'b0011,
    ALU_SUB = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_MUL = 4'b0110,
    ALU_XOR = 4'b0111
  } alu_sel_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

  // A later stage writes rs; x0 never matches.
  function automatic logic rs_match(input logic wr, input logic [4:0] rd, input logic [4:0] rs);
    return wr && (rd == rs) && (rs != 5'd0);
  endfunction

endpackage

// File: rtl/operand_forward_mux.sv
// Per-operand RAW resolution against EX/MEM and MEM/WB.
// ALU_FORWARDING_EN selects bypass muxes; otherwise every producer match is a hazard.
module operand_forward_mux import alu_pkg::*; #(
  parameter int XLEN = alu_pkg::XLEN
) (
  input  logic            active,
  input  logic [4:0]      rs,
  input  logic [XLEN-1:0] held_data,
  input  logic [4:0]      exmem_rd,
  input  logic            exmem_reg_write,
  input  logic            exmem_is_load,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [4:0]      memwb_rd,
  input  logic            memwb_reg_write,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] fwd_data,
  output logic            hazard
);

  logic ex_hit;
  logic wb_hit;

  assign ex_hit = active && rs_match(exmem_reg_write, exmem_rd, rs);
  assign wb_hit = active && rs_match(memwb_reg_write, memwb_rd, rs);

`ifdef ALU_FORWARDING_EN
  // A load in EX/MEM has no data yet; wait one cycle for it to reach MEM/WB.
  assign hazard = ex_hit && exmem_is_load;

  always_comb begin
    fwd_data = held_data;
    if (ex_hit && !exmem_is_load) begin
      fwd_data = exmem_result;
    end else if (wb_hit) begin
      fwd_data = memwb_result;
    end
  end
`else
  logic unused_fwd_inputs;

  assign hazard            = ex_hit || wb_hit;
  assign fwd_data          = held_data;
  assign unused_fwd_inputs = ^{exmem_is_load, exmem_result, memwb_result};
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX single-entry issue buffer feeding the ALU, with RAW forwarding/stalling.
// Optional macro: ALU_FORWARDING_EN (EX/MEM and MEM/WB bypass instead of stalling).
module alu_issue_stage import alu_pkg::*; #(
  parameter int XLEN = alu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  logic [3:0]      in_alu_sel,
  input  logic            in_reg_write,
  input  logic            flush,
  input  logic [4:0]      exmem_rd,
  input  logic            exmem_reg_write,
  input  logic            exmem_is_load,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [4:0]      memwb_rd,
  input  logic            memwb_reg_write,
  input  logic [XLEN-1:0] memwb_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [3:0]      ALU_Sel,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic [15:0]     stall_count
);

  stage_state_e          state_reg, state_next;
  logic [1:0][4:0]       rs_reg;
  logic [1:0][XLEN-1:0]  op_reg;
  logic [4:0]            rd_reg;
  logic [XLEN-1:0]       imm_reg;
  logic                  use_imm_reg;
  logic [3:0]            alu_sel_reg;
  logic                  reg_write_reg;
  logic [15:0]           stall_count_reg;

  // Index 0 is rs1, index 1 is rs2.
  logic [1:0][4:0]       in_rs;
  logic [1:0][XLEN-1:0]  in_data;
  logic [1:0][XLEN-1:0]  fwd_data;
  logic [1:0]            fwd_hazard;
  logic [1:0]            fwd_active;
  logic                  full, hazard, accept, drain;

  assign in_rs      = {in_rs2, in_rs1};
  assign in_data    = {in_rs2_data, in_rs1_data};
  assign fwd_active = {~use_imm_reg, 1'b1};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      operand_forward_mux #(.XLEN(XLEN)) u_mux (
        .active          (fwd_active[gi]),
        .rs              (rs_reg[gi]),
        .held_data       (op_reg[gi]),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_is_load   (exmem_is_load),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .fwd_data        (fwd_data[gi]),
        .hazard          (fwd_hazard[gi])
      );
    end
  endgenerate

  always_comb begin
    full      = (state_reg == ST_FULL);
    hazard    = |fwd_hazard;
    out_valid = full && !hazard;
    drain     = out_valid && out_ready;
    in_ready  = !flush && (!full || drain);
    accept    = in_valid && in_ready;

    state_next = state_reg;
    if (flush) begin
      state_next = ST_EMPTY;
    end else if (accept) begin
      state_next = ST_FULL;
    end else if (drain) begin
      state_next = ST_EMPTY;
    end
  end

  assign A             = fwd_data[0];
  assign B             = use_imm_reg ? imm_reg : fwd_data[1];
  assign ALU_Sel       = alu_sel_reg;
  assign out_rd        = rd_reg;
  assign out_reg_write = reg_write_reg;
  assign stall_count   = stall_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_EMPTY;
      rs_reg          <= '0;
      op_reg          <= '0;
      rd_reg          <= '0;
      imm_reg         <= '0;
      use_imm_reg     <= 1'b0;
      alu_sel_reg     <= '0;
      reg_write_reg   <= 1'b0;
      stall_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        rd_reg        <= in_rd;
        imm_reg       <= in_imm;
        use_imm_reg   <= in_use_imm;
        alu_sel_reg   <= in_alu_sel;
        reg_write_reg <= in_reg_write;
        for (int i = 0; i < 2; i++) begin
          rs_reg[i] <= in_rs[i];
          // Register-file write-through for the value retiring this cycle.
          op_reg[i] <= rs_match(memwb_reg_write, memwb_rd, in_rs[i]) ? memwb_result : in_data[i];
        end
      end else if (full && !drain) begin
        // Keep retiring producer values so they survive a long hold.
        for (int i = 0; i < 2; i++) begin
          if (rs_match(memwb_reg_write, memwb_rd, rs_reg[i])) begin
            op_reg[i] <= memwb_result;
          end
        end
      end
      if (full && (hazard || !out_ready) && (stall_count_reg != 16'hFFFF)) begin
        stall_count_reg <= stall_count_reg + 16'd1;
      end
    end
  end

endmodule
